// File: rtl/led_cmd_ctrl_pkg.sv
// led_cmd_ctrl_pkg: shared constants, FSM state type and gamma helper for the
// LED command execution stage.
// Ports: none (package).
package led_cmd_ctrl_pkg;

  localparam int CMD_BITS          = 8;
  localparam int ADDR_BITS         = 8;
  localparam int PAYLOAD_BITS      = 8;
  localparam int REPLY_FRAME_WIDTH = 24;
  localparam int PWM_STEPS         = 100;

  localparam logic [CMD_BITS-1:0]     CMD_NOP       = 8'h00;
  localparam logic [CMD_BITS-1:0]     CMD_WRITE     = 8'h01;
  localparam logic [CMD_BITS-1:0]     CMD_READ      = 8'h02;
  localparam logic [ADDR_BITS-1:0]    ADDR_NONE     = 8'h00;
  localparam logic [ADDR_BITS-1:0]    ADDR_STATUS   = 8'hFF;
  localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_NONE  = 8'h00;
  localparam logic [PAYLOAD_BITS-1:0] PCT_MAX       = 8'd100;
  localparam logic [PAYLOAD_BITS-1:0] BAD_ADDR_DATA = 8'hFF;

  // cs is active low on the board
  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_REPLY,
    ST_WAIT_CS
  } state_e;

  // Perceptual correction: round(pct^2 / 100), stays within 0..100
  function automatic logic [PAYLOAD_BITS-1:0] gamma_pct(input logic [PAYLOAD_BITS-1:0] pct);
    logic [15:0] sq;
    sq = 16'(pct) * 16'(pct) + 16'd50;
    return PAYLOAD_BITS'(sq / 16'd100);
  endfunction

endpackage

// File: rtl/led_cmd_if.sv
// led_cmd_if: decoded SPI command fields towards the controller and the read
// reply travelling back to the SPI slave.
// Signals: i_cmd/i_addr/i_payload (slave -> ctrl), slv_tx_enb/o_slv_frame (ctrl -> slave).
interface led_cmd_if;
  import led_cmd_ctrl_pkg::*;

  logic [CMD_BITS-1:0]          i_cmd;
  logic [ADDR_BITS-1:0]         i_addr;
  logic [PAYLOAD_BITS-1:0]      i_payload;
  logic                         slv_tx_enb;
  logic [REPLY_FRAME_WIDTH-1:0] o_slv_frame;

  // SPI slave side
  modport master (
    output i_cmd, i_addr, i_payload,
    input  slv_tx_enb, o_slv_frame
  );

  // command controller side
  modport slave (
    input  i_cmd, i_addr, i_payload,
    output slv_tx_enb, o_slv_frame
  );

endinterface

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one 100-step PWM channel with a shadowed duty register.
// Ports: sysclk, rst_n, tick_i (step enable), duty_i (0..100 percent), led_o.
// The duty is sampled only at the 99->0 wrap so a frame is never cut short.
module led_pwm_channel
  import led_cmd_ctrl_pkg::*;
(
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    tick_i,
  input  logic [PAYLOAD_BITS-1:0] duty_i,
  output logic                    led_o
);

  logic [6:0]              cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0] duty_act_q, duty_act_d;

  always_comb begin
    cnt_d      = cnt_q;
    duty_act_d = duty_act_q;
    if (tick_i) begin
      if (cnt_q == 7'(PWM_STEPS - 1)) begin
        cnt_d      = '0;
        duty_act_d = duty_i;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      duty_act_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      duty_act_q <= duty_act_d;
    end
  end

  // duty 0 never satisfies the compare, duty 100 always does
  assign led_o = ({1'b0, cnt_q} < duty_act_q);

endmodule

// File: rtl/led_cmd_ctrl.sv
// led_cmd_ctrl: executes decoded SPI commands against a per-LED brightness
// table, drives one PWM output per LED and builds the read reply frame.
// Ports: sysclk, rst_n (async, active low), cs (raw pin), bus (led_cmd_if.slave),
//   led[NUM_LEDS] (PWM, active high), o_err (sticky error, cleared by write to 0xFF).
// Build option: define LED_GAMMA_EN for squared duty mapping; default is linear.
module led_cmd_ctrl
  import led_cmd_ctrl_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int CLK_HZ   = 125000000,
  parameter int PWM_HZ   = 1000
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                cs,
  led_cmd_if.slave            bus,
  output logic [NUM_LEDS-1:0] led,
  output logic                o_err
);

  localparam int PRESCALE = CLK_HZ / (PWM_HZ * PWM_STEPS);
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [ADDR_BITS-1:0] NUM_LEDS_A = ADDR_BITS'(NUM_LEDS);

  // ---------------- PWM prescaler ----------------
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  assign tick = (ps_q == PS_W'(PRESCALE - 1));
  assign ps_d = tick ? '0 : ps_q + PS_W'(1);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  // ---------------- cs synchroniser + assert-edge detect ----------------
  logic cs_meta_q, cs_s_q, cs_prev_q;
  logic cs_assert_edge;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q <= CS_DEASSERT;
      cs_s_q    <= CS_DEASSERT;
      cs_prev_q <= CS_DEASSERT;
    end else begin
      cs_meta_q <= cs;
      cs_s_q    <= cs_meta_q;
      cs_prev_q <= cs_s_q;
    end
  end

  // REPLY waits for a fresh assertion: the read itself arrives while cs is
  // still low, and that frame must not consume the reply.
  assign cs_assert_edge = (cs_s_q == CS_ASSERT) && (cs_prev_q == CS_DEASSERT);

  // ---------------- frame detect ----------------
  logic arm_q, arm_d;
  logic exec;

  assign exec = arm_q && (bus.i_cmd != CMD_NOP);

  always_comb begin
    arm_d = arm_q;
    if (exec)                      arm_d = 1'b0;
    else if (bus.i_cmd == CMD_NOP) arm_d = 1'b1;
  end

  // ---------------- decode ----------------
  logic                    is_wr, is_rd, addr_ok;
  logic [PAYLOAD_BITS-1:0] pay_clamped, rd_data;

  logic [PAYLOAD_BITS-1:0] bright_q [NUM_LEDS];
  logic [PAYLOAD_BITS-1:0] bright_d [NUM_LEDS];

  assign is_wr       = (bus.i_cmd == CMD_WRITE);
  assign is_rd       = (bus.i_cmd == CMD_READ);
  assign addr_ok     = (bus.i_addr < NUM_LEDS_A);
  assign pay_clamped = (bus.i_payload > PCT_MAX) ? PCT_MAX : bus.i_payload;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (bus.i_addr == ADDR_BITS'(i)) rd_data = bright_q[i];
    end
  end

  // ---------------- command FSM ----------------
  state_e                       state_q, state_d;
  logic                         rd_pend_q, rd_pend_d;
  logic                         err_q, err_d;
  logic                         tx_q, tx_d;
  logic [REPLY_FRAME_WIDTH-1:0] frame_q, frame_d;

  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_pend_q;
    err_d     = err_q;
    tx_d      = tx_q;
    frame_d   = frame_q;
    bright_d  = bright_q;

    case (state_q)
      ST_EXEC:  state_d = rd_pend_q ? ST_REPLY : ST_IDLE;
      ST_REPLY: if (cs_assert_edge) state_d = ST_WAIT_CS;
      ST_WAIT_CS: begin
        if (cs_s_q == CS_DEASSERT) begin
          state_d = ST_IDLE;
          tx_d    = 1'b0;
          frame_d = '0;
        end
      end
      default: ;
    endcase

    // Placed after the state case so a read landing on the WAIT_CS release
    // cycle still wins and re-arms the reply.
    if (exec) begin
      rd_pend_d = is_rd;
      // writes and errors while a reply is pending leave the reply alone
      if (state_q == ST_IDLE || is_rd) state_d = ST_EXEC;

      if (is_wr) begin
        if (addr_ok) begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (bus.i_addr == ADDR_BITS'(i)) bright_d[i] = pay_clamped;
          end
          if (bus.i_payload > PCT_MAX) err_d = 1'b1;
        end else if (bus.i_addr == ADDR_STATUS) begin
          err_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else if (is_rd) begin
        tx_d    = 1'b1;
        frame_d = {CMD_READ, bus.i_addr, addr_ok ? rd_data : BAD_ADDR_DATA};
        if (!addr_ok) err_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b1;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
      tx_q      <= 1'b0;
      frame_q   <= '0;
      for (int i = 0; i < NUM_LEDS; i++) bright_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
      frame_q   <= frame_d;
      bright_q  <= bright_d;
    end
  end

  assign bus.slv_tx_enb  = tx_q;
  assign bus.o_slv_frame = frame_q;
  assign o_err           = err_q;

  // ---------------- PWM channels ----------------
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    logic [PAYLOAD_BITS-1:0] duty;

`ifdef LED_GAMMA_EN
    // gamma value registered alongside the table write; read-back stays raw
    logic [PAYLOAD_BITS-1:0] duty_q;
    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        duty_q <= '0;
      end else if (exec && is_wr && (bus.i_addr == ADDR_BITS'(g))) begin
        duty_q <= gamma_pct(pay_clamped);
      end
    end
    assign duty = duty_q;
`else
    assign duty = bright_q[g];
`endif

    led_pwm_channel u_ch (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .tick_i (tick),
      .duty_i (duty),
      .led_o  (led[g])
    );
  end

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// tb_led_cmd_ctrl: directed, table-driven bench for led_cmd_ctrl.
// Runs with prescale 2 so one PWM frame is 200 sysclk cycles.
// Honours LED_GAMMA_EN for the expected duty values.
module tb_led_cmd_ctrl;
  import led_cmd_ctrl_pkg::*;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       cs     = 1'b1;
  logic [3:0] led;
  logic       o_err;

  led_cmd_if bus ();

  led_cmd_ctrl #(
    .NUM_LEDS (4),
    .CLK_HZ   (200000),
    .PWM_HZ   (1000)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .cs     (cs),
    .bus    (bus),
    .led    (led),
    .o_err  (o_err)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;
  int exec_cnt = 0;

  always @(posedge sysclk) if (dut.exec) exec_cnt++;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [7:0]  pay;
    logic        exp_err;
    logic        exp_tx;
    logic [23:0] exp_frame;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_duty(input int pct);
`ifdef LED_GAMMA_EN
    return (pct * pct + 50) / 100;
`else
    return pct;
`endif
  endfunction

  task automatic set_fields(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
    bus.i_cmd     = c;
    bus.i_addr    = a;
    bus.i_payload = p;
  endtask

  // one SPI transaction as seen downstream: cs low, fields appear, cs high, fields NOP
  task automatic do_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
    @(negedge sysclk) cs = CS_ASSERT;
    repeat (4) @(negedge sysclk);
    set_fields(c, a, p);
    repeat (4) @(negedge sysclk);
    cs = CS_DEASSERT;
    repeat (4) @(negedge sysclk);
    set_fields(CMD_NOP, ADDR_NONE, PAYLOAD_NONE);
    repeat (4) @(negedge sysclk);
  endtask

  // high cycles over exactly one PWM frame (200 cycles = 100 steps x 2)
  task automatic measure(input int ch, output int hi);
    hi = 0;
    repeat (200) begin
      @(negedge sysclk);
      if (led[ch]) hi++;
    end
  endtask

  initial begin
    int hi;
    logic found;

    vecs[0]  = '{CMD_WRITE, 8'd2,   8'd75,  1'b0, 1'b0, 24'h000000};
    vecs[1]  = '{CMD_READ,  8'd2,   8'd0,   1'b0, 1'b1, 24'h02024B};
    vecs[2]  = '{CMD_WRITE, 8'd0,   8'd200, 1'b1, 1'b0, 24'h000000};
    vecs[3]  = '{CMD_WRITE, 8'hFF,  8'd0,   1'b0, 1'b0, 24'h000000};
    vecs[4]  = '{CMD_READ,  8'd7,   8'd0,   1'b1, 1'b1, 24'h0207FF};
    vecs[5]  = '{CMD_WRITE, 8'hFF,  8'd0,   1'b0, 1'b0, 24'h000000};
    vecs[6]  = '{CMD_WRITE, 8'd9,   8'd10,  1'b1, 1'b0, 24'h000000};
    vecs[7]  = '{CMD_READ,  8'd0,   8'd0,   1'b1, 1'b1, 24'h020064};
    vecs[8]  = '{CMD_READ,  8'd1,   8'd0,   1'b1, 1'b1, 24'h020132};
    vecs[9]  = '{8'h33,     8'd0,   8'd0,   1'b1, 1'b0, 24'h000000};
    vecs[10] = '{CMD_WRITE, 8'hFF,  8'd0,   1'b0, 1'b0, 24'h000000};
    vecs[11] = '{CMD_READ,  8'd3,   8'd0,   1'b0, 1'b1, 24'h020300};
    vecs[12] = '{CMD_WRITE, 8'd3,   8'd100, 1'b0, 1'b0, 24'h000000};
    vecs[13] = '{CMD_READ,  8'd2,   8'd0,   1'b0, 1'b1, 24'h02024B};

    set_fields(CMD_NOP, ADDR_NONE, PAYLOAD_NONE);
    repeat (3) @(negedge sysclk);

    // reset state
    check("rst_led", 32'(led), 0);
    check("rst_err", 32'(o_err), 0);
    check("rst_tx", 32'(bus.slv_tx_enb), 0);
    check("rst_frame", 32'(bus.o_slv_frame), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);

    // single write becomes visible within one PWM frame, others stay dark
    do_frame(CMD_WRITE, 8'd1, 8'd50);
    repeat (200) @(negedge sysclk);
    for (int c = 0; c < 4; c++) begin
      measure(c, hi);
      check($sformatf("w1_led%0d_hi", c), hi, (c == 1) ? 2 * exp_duty(50) : 0);
    end

    // command table
    for (int i = 0; i < NV; i++) begin
      do_frame(vecs[i].cmd, vecs[i].addr, vecs[i].pay);
      check($sformatf("v%0d_err", i), 32'(o_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_tx", i), 32'(bus.slv_tx_enb), 32'(vecs[i].exp_tx));
      check($sformatf("v%0d_frame", i), 32'(bus.o_slv_frame), 32'(vecs[i].exp_frame));
    end

    // table now 100/50/75/100
    repeat (200) @(negedge sysclk);
    measure(0, hi); check("tbl_led0_hi", hi, 2 * exp_duty(100));
    measure(1, hi); check("tbl_led1_hi", hi, 2 * exp_duty(50));
    measure(2, hi); check("tbl_led2_hi", hi, 2 * exp_duty(75));
    measure(3, hi); check("tbl_led3_hi", hi, 2 * exp_duty(100));

    // one-shot: fields held 500 cycles under cs low execute once per frame
    exec_cnt = 0;
    for (int r = 1; r <= 2; r++) begin
      @(negedge sysclk) cs = CS_ASSERT;
      repeat (4) @(negedge sysclk);
      set_fields(CMD_WRITE, 8'd2, 8'd60);
      repeat (500) @(negedge sysclk);
      cs = CS_DEASSERT;
      repeat (4) @(negedge sysclk);
      set_fields(CMD_NOP, ADDR_NONE, PAYLOAD_NONE);
      repeat (4) @(negedge sysclk);
      check($sformatf("oneshot%0d_execs", r), exec_cnt, r);
    end

    // reset in the middle of a PWM high phase with a reply and an error pending
    do_frame(CMD_WRITE, 8'd9, 8'd1);
    do_frame(CMD_READ, 8'd2, 8'd0);
    check("pre_rst_frame", 32'(bus.o_slv_frame), 32'h02023C);
    check("pre_rst_err", 32'(o_err), 1);
    repeat (200) @(negedge sysclk);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge sysclk);
      if (led[2]) found = 1'b1;
    end
    check("pre_rst_led2_seen", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_led", 32'(led), 0);
    check("mid_rst_tx", 32'(bus.slv_tx_enb), 0);
    check("mid_rst_frame", 32'(bus.o_slv_frame), 0);
    check("mid_rst_err", 32'(o_err), 0);
    @(negedge sysclk) rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
    do_frame(CMD_READ, 8'd2, 8'd0);
    check("post_rst_frame", 32'(bus.o_slv_frame), 32'h020200);
    check("post_rst_tx", 32'(bus.slv_tx_enb), 1);
    repeat (200) @(negedge sysclk);
    measure(2, hi);
    check("post_rst_led2_hi", hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
